// File: rtl/reg_access_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_access_seq_pkg : sequencer FSM states and register-file slot offsets  (rev 1.0)
// ---------------------------------------------------------------------------
package reg_access_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4
  } state_e;

  // Slot positions are relative to the CNT_CLK base of the phase counter.
  localparam int c_rd_ofs      = 0;
  localparam int c_wr_ofs      = 4;
  localparam int c_slot_period = 8;

endpackage
`default_nettype wire

// File: rtl/reg_access_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_access_seq : slot-scheduled register-file read / execute / write-back sequencer  (rev 1.0)
// ---------------------------------------------------------------------------
module reg_access_seq
  import reg_access_seq_pkg::*;
#(
  parameter int SIZE_CNT = 3,
  parameter int CNT_CLK  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [3:0]        ins_rs1,
  input  logic [3:0]        ins_rs2,
  input  logic [3:0]        ins_rd,
  input  logic              ins_wb,
  output logic [SIZE_CNT:0] cnt_clk,
  output logic              WR,
  output logic [3:0]        Read_Addr1,
  output logic [3:0]        Read_Addr2,
  output logic [3:0]        Write_Addr,
  output logic [7:0]        Write_Data,
  input  logic [7:0]        Dout1,
  input  logic [7:0]        Dout2,
  output logic [7:0]        op_a,
  output logic [7:0]        op_b,
  output logic              op_valid,
  input  logic [7:0]        res_data,
  input  logic              res_valid,
  output logic              done
);

  localparam int c_rd_int  = CNT_CLK + c_rd_ofs;
  localparam int c_wr_int  = CNT_CLK + c_wr_ofs;
  localparam int c_max_int = CNT_CLK + c_slot_period - 1;

  localparam logic [SIZE_CNT:0] c_rd_slot = c_rd_int[SIZE_CNT:0];
  localparam logic [SIZE_CNT:0] c_wr_slot = c_wr_int[SIZE_CNT:0];
  localparam logic [SIZE_CNT:0] c_cnt_max = c_max_int[SIZE_CNT:0];

  state_e            state_q, state_d;
  logic [SIZE_CNT:0] cnt_q, cnt_d;
  logic [3:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic              wb_q, wb_d;
  logic [7:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [7:0]        res_q, res_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      wb_q   <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      wb_q   <= wb_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  // Free-running phase counter; each period holds exactly one read and one write slot.
  always_comb begin
    cnt_d = (cnt_q == c_cnt_max) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    wb_d       = wb_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    done_d     = 1'b0;
    ins_ready  = 1'b0;
    op_valid   = 1'b0;
    WR         = 1'b0;
    Read_Addr1 = '0;
    Read_Addr2 = '0;
    Write_Addr = '0;
    Write_Data = '0;

    unique case (state_q)
      IDLE: begin
        ins_ready = 1'b1;
        if (ins_valid) begin
          rs1_d   = ins_rs1;
          rs2_d   = ins_rs2;
          rd_d    = ins_rd;
          wb_d    = ins_wb;
          state_d = READ;
        end
      end
      READ: begin
        Read_Addr1 = rs1_q;
        Read_Addr2 = rs2_q;
        if (cnt_q == c_rd_slot) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        // Addresses stay up so a synchronous-read register file still sees them.
        Read_Addr1 = rs1_q;
        Read_Addr2 = rs2_q;
        op_a_d     = Dout1;
        op_b_d     = Dout2;
        state_d    = EXEC;
      end
      EXEC: begin
        op_valid = 1'b1;
        if (res_valid) begin
          res_d = res_data;
          if (wb_q) begin
            state_d = WRITE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        Write_Addr = rd_q;
        Write_Data = res_q;
        if (cnt_q == c_wr_slot) begin
          WR      = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cnt_clk = cnt_q;
  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_access_seq : scoreboard bench for reg_access_seq with a synchronous register-file model  (rev 1.0)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_access_seq;

  localparam int SIZE_CNT = 3;
  localparam int CNT_CLK  = 2;
  localparam int WR_SLOT  = CNT_CLK + 4;
  localparam int CNT_MAX  = CNT_CLK + 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ins_valid = 1'b0;
  logic              ins_ready;
  logic [3:0]        ins_rs1 = '0, ins_rs2 = '0, ins_rd = '0;
  logic              ins_wb = 1'b0;
  logic [SIZE_CNT:0] cnt_clk;
  logic              WR;
  logic [3:0]        Read_Addr1, Read_Addr2, Write_Addr;
  logic [7:0]        Write_Data, Dout1, Dout2, op_a, op_b;
  logic              op_valid;
  logic [7:0]        res_data = '0;
  logic              res_valid = 1'b0;
  logic              done;

  always #5 clk = ~clk;

  reg_access_seq #(.SIZE_CNT(SIZE_CNT), .CNT_CLK(CNT_CLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_rs1(ins_rs1), .ins_rs2(ins_rs2), .ins_rd(ins_rd), .ins_wb(ins_wb),
    .cnt_clk(cnt_clk), .WR(WR),
    .Read_Addr1(Read_Addr1), .Read_Addr2(Read_Addr2),
    .Write_Addr(Write_Addr), .Write_Data(Write_Data),
    .Dout1(Dout1), .Dout2(Dout2),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .res_data(res_data), .res_valid(res_valid), .done(done)
  );

  // Register file: synchronous read and write, preloaded with Rn = n*0x11.
  logic [7:0] rf [16];
  logic       rf_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'(i * 17);
      rf_loaded <= 1'b1;
    end else if (WR) begin
      rf[Write_Addr] <= Write_Data;
    end
    Dout1 <= rf[Read_Addr1];
    Dout2 <= rf[Read_Addr2];
  end

  logic [7:0] exp_rf [16];
  initial for (int i = 0; i < 16; i++) exp_rf[i] = 8'(i * 17);

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t wq[$];
  wr_t we;
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_wr = 0;
  int  cyc = 0;
  int  wr_cyc = 0;

  always @(posedge clk) cyc++;

  // Every write strobe must match the oldest pending expected write, on the write slot.
  always @(negedge clk) begin
    if (rst_n && WR === 1'b1) begin
      n_wr++;
      wr_cyc = cyc;
      n_cmp++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_wr: got addr=%0d data=%h cnt=%0d, required no write", Write_Addr, Write_Data, cnt_clk);
      end else begin
        we = wq.pop_front();
        if ({Write_Addr, Write_Data, cnt_clk} !== {we.a, we.d, 4'(WR_SLOT)}) begin
          n_err++;
          $display("FAIL wr_content: got addr=%0d data=%h cnt=%0d, required addr=%0d data=%h cnt=%0d",
                   Write_Addr, Write_Data, cnt_clk, we.a, we.d, WR_SLOT);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input logic w);
    int t = 0;
    @(negedge clk);
    while (ins_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    ins_rs1 = a; ins_rs2 = b; ins_rd = d; ins_wb = w; ins_valid = 1'b1;
    @(negedge clk);
    ins_valid = 1'b0;
  endtask

  task automatic wait_op(output bit ok);
    int t = 0;
    while (op_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = (op_valid === 1'b1);
  endtask

  task automatic wait_done(output bit ok);
    int t = 0;
    while (done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic respond(input logic [7:0] d);
    res_data = d;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cnt_clk, WR, Read_Addr1, Read_Addr2, Write_Addr, Write_Data, op_a, op_b, op_valid, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got cnt=%0d WR=%b ra1=%0d ra2=%0d wa=%0d wd=%h a=%h b=%h ov=%b done=%b, required all zero",
               cnt_clk, WR, Read_Addr1, Read_Addr2, Write_Addr, Write_Data, op_a, op_b, op_valid, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ins_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, required 1", ins_ready);
    end
  endtask

  // Called one cycle after reset release, so the counter has advanced to 1.
  task automatic test_counter;
    logic [SIZE_CNT:0] e = 1;
    for (int k = 0; k < 22; k++) begin
      n_cmp++;
      if (cnt_clk !== e) begin
        n_err++;
        $display("FAIL cnt_seq: got %0d, required %0d", cnt_clk, e);
      end
      @(negedge clk);
      e = (e == 4'(CNT_MAX)) ? '0 : e + 1'b1;
    end
  endtask

  task automatic test_wb_write;
    bit ok;
    issue(4'd1, 4'd2, 4'd3, 1'b1);
    n_cmp++;
    if ({Read_Addr1, Read_Addr2, WR} !== {4'd1, 4'd2, 1'b0}) begin
      n_err++;
      $display("FAIL read_addr: got ra1=%0d ra2=%0d WR=%b, required 1 2 0", Read_Addr1, Read_Addr2, WR);
    end
    wait_op(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL op_valid_timeout: got 0, required 1");
      return;
    end
    n_cmp++;
    if ({op_a, op_b, cnt_clk} !== {8'h11, 8'h22, 4'(CNT_CLK + 2)}) begin
      n_err++;
      $display("FAIL operands: got a=%h b=%h cnt=%0d, required a=11 b=22 cnt=%0d", op_a, op_b, cnt_clk, CNT_CLK + 2);
    end
    wq.push_back('{a: 4'd3, d: 8'h33});
    exp_rf[3] = 8'h33;
    respond(8'h33);
    wait_done(ok);
    n_cmp++;
    if (!ok || cnt_clk !== 4'(WR_SLOT + 1)) begin
      n_err++;
      $display("FAIL wb_done: got done=%b cnt=%0d, required done=1 cnt=%0d", done, cnt_clk, WR_SLOT + 1);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || wq.size() != 0) begin
      n_err++;
      $display("FAIL wb_pulse: got done=%b pending=%0d, required done=0 pending=0", done, wq.size());
    end
  endtask

  task automatic test_no_wb;
    bit ok;
    int n0 = n_wr;
    issue(4'd4, 4'd6, 4'd9, 1'b0);
    wait_op(ok);
    n_cmp++;
    if (!ok || op_a !== exp_rf[4] || op_b !== exp_rf[6]) begin
      n_err++;
      $display("FAIL nowb_operands: got ov=%b a=%h b=%h, required ov=1 a=%h b=%h", op_valid, op_a, op_b, exp_rf[4], exp_rf[6]);
    end
    respond(8'hA5);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL nowb_done: got %b, required 1", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL nowb_pulse: got %b, required 0", done);
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (n_wr != n0) begin
      n_err++;
      $display("FAIL nowb_no_write: got %0d writes, required 0", n_wr - n0);
    end
  endtask

  task automatic test_late_result;
    bit ok;
    int t = 0;
    int n0;
    int t0;
    issue(4'd2, 4'd1, 4'd7, 1'b1);
    wait_op(ok);
    while (cnt_clk !== 4'd7 && t < 12) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!ok || op_valid !== 1'b1 || cnt_clk !== 4'd7) begin
      n_err++;
      $display("FAIL late_hold: got ov=%b cnt=%0d, required ov=1 cnt=7", op_valid, cnt_clk);
      return;
    end
    wq.push_back('{a: 4'd7, d: 8'hC3});
    exp_rf[7] = 8'hC3;
    n0 = n_wr;
    t0 = cyc;
    respond(8'hC3);
    t = 0;
    while (n_wr == n0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (n_wr == n0 || wr_cyc - t0 != 9) begin
      n_err++;
      $display("FAIL late_latency: got writes=%0d delay=%0d, required writes=1 delay=9", n_wr - n0, wr_cyc - t0);
    end
    wait_done(ok);
  endtask

  task automatic test_reset_in_exec;
    bit ok;
    int n0 = n_wr;
    issue(4'd1, 4'd2, 4'd8, 1'b1);
    wait_op(ok);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || {cnt_clk, WR, Read_Addr1, Read_Addr2, Write_Addr, Write_Data, op_a, op_b, op_valid, done} !== '0) begin
      n_err++;
      $display("FAIL exec_reset_outputs: got ok=%b cnt=%0d WR=%b wa=%0d wd=%h a=%h b=%h ov=%b done=%b, required ok=1 and all zero",
               ok, cnt_clk, WR, Write_Addr, Write_Data, op_a, op_b, op_valid, done);
    end
    rst_n = 1'b1;
    respond(8'hEE);
    n_cmp++;
    if (ins_ready !== 1'b1) begin
      n_err++;
      $display("FAIL exec_reset_ready: got %b, required 1", ins_ready);
    end
    repeat (25) @(negedge clk);
    n_cmp++;
    if (n_wr != n0) begin
      n_err++;
      $display("FAIL exec_reset_no_write: got %0d writes, required 0", n_wr - n0);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    issue(4'd1, 4'd2, 4'd5, 1'b1);
    wait_op(ok);
    wq.push_back('{a: 4'd5, d: 8'h5A});
    exp_rf[5] = 8'h5A;
    respond(8'h5A);
    issue(4'd5, 4'd3, 4'd10, 1'b0);
    wait_op(ok);
    n_cmp++;
    if (!ok || op_a !== exp_rf[5] || op_b !== exp_rf[3]) begin
      n_err++;
      $display("FAIL b2b_operands: got ov=%b a=%h b=%h, required ov=1 a=%h b=%h", op_valid, op_a, op_b, exp_rf[5], exp_rf[3]);
    end
    respond(8'h00);
    wait_done(ok);
    n_cmp++;
    if (!ok || wq.size() != 0) begin
      n_err++;
      $display("FAIL b2b_complete: got done=%b pending=%0d, required done=1 pending=0", ok, wq.size());
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_wb_write();
    test_no_wb();
    test_late_result();
    test_reset_in_exec();
    test_back_to_back();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wq.size() != 0) begin
      n_err++;
      $display("FAIL final_pending: got %0d writes outstanding, required 0", wq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
